// File: rtl/launch_sequencer_pkg.sv
// Shared types for the launch sequencer: FSM states, phase codes,
// and the registered status flags decoded from a state.
package launch_sequencer_pkg;

  localparam int SEQ_W = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN_A  = 3'd1,
    WAIT_A = 3'd2,
    RUN_B  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_A    = 2'd1;
  localparam logic [1:0] PH_B    = 2'd2;
  localparam logic [1:0] PH_DONE = 2'd3;

  typedef struct packed {
    logic [1:0] phase;
    logic       running;
    logic       waiting;
  } flags_t;

  function automatic flags_t decode(state_t s);
    flags_t f;
    f = '{PH_IDLE, 1'b0, 1'b0};
    case (s)
      RUN_A:   f = '{PH_A,    1'b1, 1'b0};
      WAIT_A:  f = '{PH_A,    1'b0, 1'b1};
      RUN_B:   f = '{PH_B,    1'b1, 1'b0};
      DONE:    f = '{PH_DONE, 1'b0, 1'b1};
      default: f = '{PH_IDLE, 1'b0, 1'b0};
    endcase
    return f;
  endfunction

endpackage

// File: rtl/launch_sequencer_if.sv
// Control/status bundle between the front end and the launch sequencer.
// The front end is master; the sequencer is slave.
interface launch_sequencer_if;
  import launch_sequencer_pkg::*;

  logic             btn;
  logic             abort;
  logic             tick;
  logic [SEQ_W-1:0] seq;
  logic [1:0]       phase;
  logic             running;
  logic             waiting;

  modport master (
    output btn, abort, tick,
    input  seq, phase, running, waiting
  );

  modport slave (
    input  btn, abort, tick,
    output seq, phase, running, waiting
  );
endinterface

// File: rtl/btn_sync_edge.sv
// Button synchroniser plus rising-edge detect; a level already high
// when reset releases must go low before it can produce a rise.
module btn_sync_edge #(
  parameter int SYNC_W = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d_async,
  output logic rise
);

  logic [SYNC_W-1:0] sync;
  logic [SYNC_W-1:0] fill;
  logic              prev;
  logic              armed;

  // fill marks when the last stage holds a real sample, not reset zeros
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      fill  <= '0;
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync <= {sync[SYNC_W-2:0], d_async};
      fill <= {fill[SYNC_W-2:0], 1'b1};
      prev <= sync[SYNC_W-1];
      if (fill[SYNC_W-1] && !sync[SYNC_W-1])
        armed <= 1'b1;
    end
  end

  assign rise = armed & sync[SYNC_W-1] & ~prev;

endmodule

// File: rtl/launch_sequencer.sv
// Two-phase countdown sequencer: RUN_A to END_A, button hold,
// RUN_B to END_B, button hold, then back to IDLE.
module launch_sequencer
  import launch_sequencer_pkg::*;
#(
  parameter logic [SEQ_W-1:0] END_A  = 6'd9,
  parameter logic [SEQ_W-1:0] END_B  = 6'd59,
  parameter int               SYNC_W = 2
) (
  input logic               clk_in,
  input logic               rst,
  launch_sequencer_if.slave bus
);

  if (END_A == '0 || END_A >= END_B) begin : g_bad_ends
    $error("launch_sequencer: need 0 < END_A < END_B");
  end
  if (SYNC_W < 2) begin : g_bad_sync
    $error("launch_sequencer: SYNC_W must be >= 2");
  end

  state_t           state;
  flags_t           flg;
  logic [SEQ_W-1:0] seq;
  logic [SEQ_W-1:0] seq_inc;
  logic             rise;

  btn_sync_edge #(.SYNC_W(SYNC_W)) u_btn (
    .clk_in  (clk_in),
    .rst     (rst),
    .d_async (bus.btn),
    .rise    (rise)
  );

  assign seq_inc = seq + SEQ_W'(1);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      seq   <= '0;
      flg   <= '0;
    end else if (bus.abort) begin
      state <= IDLE;
      seq   <= '0;
      flg   <= decode(IDLE);
    end else begin
      case (state)
        IDLE: if (rise) begin
          state <= RUN_A;
          seq   <= '0;
          flg   <= decode(RUN_A);
        end
        RUN_A: if (bus.tick) begin
          seq <= seq_inc;
          if (seq_inc == END_A) begin
            state <= WAIT_A;
            flg   <= decode(WAIT_A);
          end
        end
        WAIT_A: if (rise) begin
          state <= RUN_B;
          flg   <= decode(RUN_B);
        end
        RUN_B: if (bus.tick) begin
          seq <= seq_inc;
          if (seq_inc == END_B) begin
            state <= DONE;
            flg   <= decode(DONE);
          end
        end
        DONE: if (rise) begin
          state <= IDLE;
          seq   <= '0;
          flg   <= decode(IDLE);
        end
        default: begin
          state <= IDLE;
          seq   <= '0;
          flg   <= decode(IDLE);
        end
      endcase
    end
  end

  assign bus.seq     = seq;
  assign bus.phase   = flg.phase;
  assign bus.running = flg.running;
  assign bus.waiting = flg.waiting;

endmodule

// File: tb/tb_launch_sequencer.sv
// Bench for launch_sequencer: directed scenarios plus a randomized run
// checked against a phase/hold behavioural model.
module tb_launch_sequencer;

  localparam logic [5:0] EA = 6'd3;
  localparam logic [5:0] EB = 6'd6;

  logic clk_in = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [9:0] want;
  logic [9:0] got;

  always #5 clk_in = ~clk_in;

  launch_sequencer_if bus();

  launch_sequencer #(
    .END_A  (EA),
    .END_B  (EB),
    .SYNC_W (2)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct packed {
    logic [5:0] seq;
    logic [1:0] ph;
    logic       hold;
  } mstate_t;

  mstate_t    m;
  logic [2:0] smp;
  int         nsmp;

  function automatic mstate_t m_step(mstate_t s, logic r, logic t, logic a);
    mstate_t n;
    n = s;
    if (a) n = '0;
    else case (s.ph)
      2'd0: if (r) n = '{6'd0, 2'd1, 1'b0};
      2'd1: if (s.hold) begin
              if (r) begin n.ph = 2'd2; n.hold = 1'b0; end
            end else if (t) begin
              n.seq  = 6'(s.seq + 6'd1);
              n.hold = (n.seq == EA);
            end
      2'd2: if (t) begin
              n.seq = 6'(s.seq + 6'd1);
              if (n.seq == EB) n.ph = 2'd3;
            end
      default: if (r) n = '0;
    endcase
    return n;
  endfunction

  // A rise is a sampled 0 followed by a sampled 1, acted on two edges later
  always @(posedge clk_in or posedge rst) begin
    if (rst) begin
      m    <= '0;
      smp  <= '0;
      nsmp <= 0;
    end else begin
      m   <= m_step(m, nsmp >= 3 && smp[1] && !smp[2], bus.tick, bus.abort);
      smp <= {smp[1:0], bus.btn};
      if (nsmp < 3) nsmp <= nsmp + 1;
    end
  end

  function automatic logic [9:0] m_vec();
    logic run, wt;
    run = (m.ph == 2'd1 && !m.hold) || m.ph == 2'd2;
    wt  = (m.ph == 2'd1 && m.hold) || m.ph == 2'd3;
    return {m.seq, m.ph, run, wt};
  endfunction

  task automatic idle(int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic press();
    bus.btn = 1'b1;
    @(negedge clk_in);
    bus.btn = 1'b0;
    idle(2);
  endtask

  task automatic tick1();
    bus.tick = 1'b1;
    @(negedge clk_in);
    bus.tick = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    @(negedge clk_in);
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.btn = 1'b0; bus.tick = 1'b0; bus.abort = 1'b0;
    @(negedge clk_in);
    got = {bus.seq, bus.phase, bus.running, bus.waiting};
    checks++;
    if (got !== 10'd0) begin
      errors++; $display("FAIL reset_hold got %h want %h", got, 10'd0);
    end
    idle(2);
    rst = 1'b0;
    idle(4);
    press();
    tick1();
    want = {6'd1, 2'd1, 1'b1, 1'b0};
    got = {bus.seq, bus.phase, bus.running, bus.waiting};
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset_prerun got %h want %h", got, want);
    end
    #2 rst = 1'b1;
    #1;
    got = {bus.seq, bus.phase, bus.running, bus.waiting};
    checks++;
    if (got !== 10'd0) begin
      errors++; $display("FAIL reset_async got %h want %h", got, 10'd0);
    end
    @(negedge clk_in);
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_nominal();
    press();
    want = {6'd0, 2'd1, 1'b1, 1'b0};
    got = {bus.seq, bus.phase, bus.running, bus.waiting};
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL nom_start got %h want %h", got, want);
    end
    for (int i = 1; i <= 3; i++) begin
      tick1();
      want = {6'(i), 2'd1, (i < 3), (i == 3)};
      got = {bus.seq, bus.phase, bus.running, bus.waiting};
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL nom_a%0d got %h want %h", i, got, want);
      end
    end
    press();
    want = {6'd3, 2'd2, 1'b1, 1'b0};
    got = {bus.seq, bus.phase, bus.running, bus.waiting};
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL nom_runb got %h want %h", got, want);
    end
    for (int i = 4; i <= 6; i++) begin
      tick1();
      want = {6'(i), (i == 6) ? 2'd3 : 2'd2, (i < 6), (i == 6)};
      got = {bus.seq, bus.phase, bus.running, bus.waiting};
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL nom_b%0d got %h want %h", i, got, want);
      end
    end
    press();
    got = {bus.seq, bus.phase, bus.running, bus.waiting};
    checks++;
    if (got !== 10'd0) begin
      errors++; $display("FAIL nom_end got %h want %h", got, 10'd0);
    end
    idle(4);
  endtask

  task automatic test_hold();
    press();
    repeat (3) tick1();
    for (int i = 0; i < 5; i++) begin
      tick1();
      want = {6'd3, 2'd1, 1'b0, 1'b1};
      got = {bus.seq, bus.phase, bus.running, bus.waiting};
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL hold_waita%0d got %h want %h", i, got, want);
      end
    end
    bus.btn = 1'b1;
    idle(20);
    want = {6'd3, 2'd2, 1'b1, 1'b0};
    got = {bus.seq, bus.phase, bus.running, bus.waiting};
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL hold_btn_runb got %h want %h", got, want);
    end
    bus.btn = 1'b0;
    idle(3);
    repeat (3) tick1();
    want = {6'd6, 2'd3, 1'b0, 1'b1};
    got = {bus.seq, bus.phase, bus.running, bus.waiting};
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL hold_done got %h want %h", got, want);
    end
    bus.btn = 1'b1;
    idle(20);
    got = {bus.seq, bus.phase, bus.running, bus.waiting};
    checks++;
    if (got !== 10'd0) begin
      errors++; $display("FAIL hold_one_rise got %h want %h", got, 10'd0);
    end
    bus.btn = 1'b0;
    idle(4);
  endtask

  task automatic test_collision();
    press();
    repeat (3) tick1();
    bus.btn = 1'b1;
    @(negedge clk_in);
    bus.btn = 1'b0;
    @(negedge clk_in);
    tick1();
    want = {6'd3, 2'd2, 1'b1, 1'b0};
    got = {bus.seq, bus.phase, bus.running, bus.waiting};
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL coll_waita got %h want %h", got, want);
    end
    do_abort();
    idle(3);
    press();
    tick1();
    bus.btn = 1'b1;
    @(negedge clk_in);
    bus.btn = 1'b0;
    @(negedge clk_in);
    tick1();
    want = {6'd2, 2'd1, 1'b1, 1'b0};
    got = {bus.seq, bus.phase, bus.running, bus.waiting};
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL coll_runa got %h want %h", got, want);
    end
    do_abort();
    idle(3);
  endtask

  task automatic test_abort();
    press();
    repeat (3) tick1();
    press();
    repeat (2) tick1();
    want = {6'd5, 2'd2, 1'b1, 1'b0};
    got = {bus.seq, bus.phase, bus.running, bus.waiting};
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL abort_pre got %h want %h", got, want);
    end
    bus.btn = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk_in);
    got = {bus.seq, bus.phase, bus.running, bus.waiting};
    checks++;
    if (got !== 10'd0) begin
      errors++; $display("FAIL abort_next got %h want %h", got, 10'd0);
    end
    idle(4);
    bus.abort = 1'b0;
    idle(6);
    got = {bus.seq, bus.phase, bus.running, bus.waiting};
    checks++;
    if (got !== 10'd0) begin
      errors++; $display("FAIL abort_btn_held got %h want %h", got, 10'd0);
    end
    bus.btn = 1'b0;
    idle(4);
  endtask

  task automatic test_latency();
    @(posedge clk_in);
    #8 bus.btn = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk_in);
      #1;
      checks++;
      if (bus.phase !== ((e == 2) ? 2'd1 : 2'd0)) begin
        errors++;
        $display("FAIL latency_k%0d got %0d want %0d", e, bus.phase,
                 (e == 2) ? 1 : 0);
      end
    end
    @(negedge clk_in);
    bus.btn = 1'b0;
    do_abort();
    idle(3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk_in);
      want = m_vec();
      got = {bus.seq, bus.phase, bus.running, bus.waiting};
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL rand_%0d got %h want %h", i, got, want);
      end
      if ($urandom_range(0, 7) == 0) bus.btn = ~bus.btn;
      bus.tick  = ($urandom_range(0, 2) == 0);
      bus.abort = ($urandom_range(0, 59) == 0);
    end
    bus.btn = 1'b0; bus.tick = 1'b0; bus.abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_hold();
    test_collision();
    test_abort();
    test_latency();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
